// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared definitions for the MEM-stage SRAM data controller.
//   state_t / IDLE, LO, HI, DONE : controller FSM encoding
//   HALF_LO / HALF_HI            : half-word select bit appended to the word index
//   DEFAULT_BASE_ADDR            : byte address that maps onto SRAM half-word 0
//   CNT_W                        : wait counter width, wide enough for up to 15 wait cycles
package sram_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t LO   = 2'd1;
    localparam state_t HI   = 2'd2;
    localparam state_t DONE = 2'd3;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter
// Counts the clock cycles spent on one SRAM half-word access.
//   clk   in   system clock
//   rst   in   synchronous, active-high reset
//   clear in   return the count to zero on the next edge
//   cnt   out  current cycle index within the access (0 .. WAIT_CYCLES-1)
//   last  out  high on the final cycle of the access
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(WAIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_data_controller.sv
// sram_data_controller
// MEM-stage responder that serves one 32-bit load or store from a 16-bit
// asynchronous SRAM as two half-word accesses (low half first).
//   clk, rst                  system clock, synchronous active-high reset
//   rd_en, wr_en              request from the EXEC stage register (write wins)
//   address, write_data       byte address (word aligned) and store data
//   read_data                 load result, valid while ready=1 after a read
//   ready                     0 while busy; the pipeline freezes on ~ready
//   sram_addr                 half-word address
//   sram_dq_o/_i/_oe          pad data out, pad data in, pad output enable
//   sram_we_n/oe_n/ce_n/ub_n/lb_n  active-low SRAM strobes
module sram_data_controller
    import sram_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    state_t             state;
    logic               op_write;
    logic [SRAM_AW-2:0] widx;
    logic [31:0]        wdata;
    logic [31:0]        offset;
    logic               request;
    logic               in_access;
    logic               half;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               unused_addr_bits;

    // Word index relative to BASE_ADDR; the upper bits are dropped so that
    // out-of-range addresses wrap around the SRAM instead of faulting.
    assign offset           = address - BASE_ADDR;
    assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0], cnt};

    assign request   = rd_en | wr_en;
    assign in_access = (state == LO) || (state == HI);
    assign half      = (state == HI) ? HALF_HI : HALF_LO;

    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

    // The counter idles at zero outside an access and wraps at the end of
    // each half, so both halves start counting from 0.
    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk  (clk),
        .rst  (rst),
        .clear(last | ~in_access),
        .cnt  (cnt),
        .last (last)
    );

    // The request is latched at acceptance so the pipeline registers may
    // change freely afterwards; read halves are captured on the final cycle
    // of each access, when the SRAM output has had the full wait to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_write  <= 1'b0;
            widx      <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state    <= LO;
                        op_write <= wr_en;
                        widx     <= offset[SRAM_AW:2];
                        wdata    <= write_data;
                    end
                end
                LO: begin
                    if (last) begin
                        state <= HI;
                        if (!op_write) begin
                            read_data[15:0] <= sram_dq_i;
                        end
                    end
                end
                HI: begin
                    if (last) begin
                        state <= DONE;
                        if (!op_write) begin
                            read_data[31:16] <= sram_dq_i;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes and pad controls decode directly from the registered state.
    // WE is released on the final cycle of a write half so the data and
    // address stay valid past its rising edge.
    always_comb begin
        ready      = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        case (state)
            IDLE: ready = ~request;
            DONE: ready = 1'b1;
            LO, HI: begin
                sram_addr = {widx, half};
                if (op_write) begin
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = (half == HALF_HI) ? wdata[31:16] : wdata[15:0];
                    sram_we_n  = last;
                end else begin
                    sram_oe_n = 1'b0;
                end
            end
            default: ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sram_data_controller.sv
// tb_sram_data_controller
// Two controller instances share a clock and reset: lane 0 uses 2 wait
// cycles, lane 1 uses 3. Each lane has its own asynchronous SRAM model and a
// transaction-level reference model that predicts every output each cycle.
module tb_sram_data_controller;

    localparam int AW = 18;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic          rd_en      [2];
    logic          wr_en      [2];
    logic [31:0]   address    [2];
    logic [31:0]   write_data [2];
    logic [31:0]   read_data  [2];
    logic          ready      [2];
    logic [AW-1:0] sram_addr  [2];
    logic [15:0]   sram_dq_o  [2];
    logic [15:0]   sram_dq_i  [2];
    logic          sram_dq_oe [2];
    logic          sram_we_n  [2];
    logic          sram_oe_n  [2];
    logic          sram_ce_n  [2];
    logic          sram_ub_n  [2];
    logic          sram_lb_n  [2];

    int checks_total  = 0;
    int checks_passed = 0;

    logic [AW-1:0] wr_addr_q [$];
    logic [15:0]   wr_dq_q   [$];
    logic [AW-1:0] rd_first_addr;
    logic [31:0]   done_read_data;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input int g, input logic rd, input logic wr,
                                  input logic [31:0] a, input logic [31:0] d);
        rd_en[g]      = rd;
        wr_en[g]      = wr;
        address[g]    = a;
        write_data[g] = d;
    endtask

    // Drives one request from a cycle boundary (+1) and holds it until the
    // edge that ends the ready=1 cycle, counting busy cycles on the way.
    task automatic do_txn(input int g, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int low_cnt);
        bit seen_rd;
        wr_addr_q.delete();
        wr_dq_q.delete();
        seen_rd = 0;
        low_cnt = 0;
        rd_first_addr = '1;
        apply_stimulus(g, rd, wr, a, d);
        forever begin
            @(negedge clk);
            if (!sram_we_n[g]) begin
                wr_addr_q.push_back(sram_addr[g]);
                wr_dq_q.push_back(sram_dq_o[g]);
            end
            if (!sram_oe_n[g] && !seen_rd) begin
                rd_first_addr = sram_addr[g];
                seen_rd = 1;
            end
            if (ready[g]) begin
                done_read_data = read_data[g];
                break;
            end
            low_cnt++;
            if (low_cnt > 100) begin
                checks_total++;
                $display("[TB] FAIL lane%0d ready timeout: got busy %0d cycles, expected done", g, low_cnt);
                break;
            end
        end
        @(posedge clk);
        #1;
        apply_stimulus(g, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int WC = (g == 0) ? 2 : 3;

        logic [15:0] mem [0:(1<<AW)-1];
        logic [15:0] hmem [int];
        int          k;
        logic        op_wr;
        int          widx;
        logic [31:0] wdata;
        logic [31:0] exp_rd;

        sram_data_controller #(
            .BASE_ADDR  (32'd1024),
            .SRAM_AW    (AW),
            .WAIT_CYCLES(WC)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .rd_en     (rd_en[g]),
            .wr_en     (wr_en[g]),
            .address   (address[g]),
            .write_data(write_data[g]),
            .read_data (read_data[g]),
            .ready     (ready[g]),
            .sram_addr (sram_addr[g]),
            .sram_dq_o (sram_dq_o[g]),
            .sram_dq_i (sram_dq_i[g]),
            .sram_dq_oe(sram_dq_oe[g]),
            .sram_we_n (sram_we_n[g]),
            .sram_oe_n (sram_oe_n[g]),
            .sram_ce_n (sram_ce_n[g]),
            .sram_ub_n (sram_ub_n[g]),
            .sram_lb_n (sram_lb_n[g])
        );

        function automatic logic [15:0] half_at(input int a);
            return hmem.exists(a) ? hmem[a] : (16'(a) ^ 16'hA5A5);
        endfunction

        initial begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] = 16'(i) ^ 16'hA5A5;
            end
            k      = 0;
            op_wr  = 1'b0;
            widx   = 0;
            wdata  = '0;
            exp_rd = '0;
        end

        // Asynchronous SRAM: data appears while OE is low, and a write lands
        // on every edge where WE is low with the pad driven.
        assign sram_dq_i[g] = !sram_oe_n[g] ? mem[sram_addr[g]] : 16'h0000;

        always @(posedge clk) begin
            if (!sram_we_n[g] && sram_dq_oe[g]) begin
                mem[sram_addr[g]] = sram_dq_o[g];
            end
        end

        // Reference model: k is the cycle number since the request was
        // accepted (0 = idle or request cycle). Outputs follow from where k
        // falls in the timeline of two WC-cycle halves plus one done cycle.
        always @(negedge clk) begin : model
            logic        e_ready, e_we, e_oe, e_dqoe, hi, in_acc;
            logic [15:0] e_dq;
            int          pos, ha;
            e_ready = 1'b0;
            e_we    = 1'b1;
            e_oe    = 1'b1;
            e_dqoe  = 1'b0;
            e_dq    = '0;
            hi      = 1'b0;
            in_acc  = 1'b0;
            pos     = 0;
            ha      = 0;
            if (k == 0) begin
                e_ready = !(rd_en[g] || wr_en[g]);
            end else if (k == 2*WC + 1) begin
                e_ready = 1'b1;
            end else begin
                in_acc = 1'b1;
                hi     = (k > WC);
                pos    = hi ? k - WC - 1 : k - 1;
                ha     = widx * 2 + int'(hi);
                if (op_wr) begin
                    e_dqoe = 1'b1;
                    e_dq   = hi ? wdata[31:16] : wdata[15:0];
                    e_we   = (pos == WC - 1);
                end else begin
                    e_oe = 1'b0;
                end
            end

            check_output($sformatf("lane%0d ready k=%0d", g, k), 32'(ready[g]), 32'(e_ready));
            check_output($sformatf("lane%0d we_n k=%0d", g, k), 32'(sram_we_n[g]), 32'(e_we));
            check_output($sformatf("lane%0d oe_n k=%0d", g, k), 32'(sram_oe_n[g]), 32'(e_oe));
            check_output($sformatf("lane%0d dq_oe k=%0d", g, k), 32'(sram_dq_oe[g]), 32'(e_dqoe));
            check_output($sformatf("lane%0d read_data k=%0d", g, k), read_data[g], exp_rd);
            check_output($sformatf("lane%0d ce/ub/lb", g),
                         32'({sram_ce_n[g], sram_ub_n[g], sram_lb_n[g]}), 32'd0);
            if (in_acc) begin
                check_output($sformatf("lane%0d sram_addr k=%0d", g, k), 32'(sram_addr[g]), 32'(ha));
            end
            if (e_dqoe) begin
                check_output($sformatf("lane%0d dq_o k=%0d", g, k), 32'(sram_dq_o[g]), 32'(e_dq));
            end

            if (in_acc && op_wr && !e_we) begin
                hmem[ha] = e_dq;
            end
            if (in_acc && !op_wr && pos == WC - 1) begin
                if (hi) exp_rd[31:16] = half_at(ha);
                else    exp_rd[15:0]  = half_at(ha);
            end

            if (rst) begin
                k      = 0;
                exp_rd = '0;
            end else if (k == 0) begin
                if (rd_en[g] || wr_en[g]) begin
                    op_wr = wr_en[g];
                    widx  = int'(((address[g] - 32'd1024) >> 2) % (1 << (AW - 1)));
                    wdata = write_data[g];
                    k     = 1;
                end
            end else if (k == 2*WC + 1) begin
                k = 0;
            end else begin
                k++;
            end
        end
    end

    initial begin
        int low;
        int low2;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(i, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] idle after reset");
        @(negedge clk);
        check_output("reset ready", 32'(ready[0]), 32'd1);
        check_output("reset we_n", 32'(sram_we_n[0]), 32'd1);
        check_output("reset oe_n", 32'(sram_oe_n[0]), 32'd1);
        check_output("reset dq_oe", 32'(sram_dq_oe[0]), 32'd0);
        check_output("reset read_data", read_data[0], 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] write 0xDEADBEEF to 1032");
        do_txn(0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, low);
        check_output("write busy cycles", 32'(low), 32'd5);
        check_output("write we_n low count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() >= 2) begin
            check_output("write lo addr", 32'(wr_addr_q[0]), 32'd4);
            check_output("write lo dq", 32'(wr_dq_q[0]), 32'h0000BEEF);
            check_output("write hi addr", 32'(wr_addr_q[1]), 32'd5);
            check_output("write hi dq", 32'(wr_dq_q[1]), 32'h0000DEAD);
        end

        $display("[TB] read back 1032");
        do_txn(0, 1'b1, 1'b0, 32'd1032, 32'd0, low);
        check_output("read busy cycles", 32'(low), 32'd5);
        check_output("read data in done", done_read_data, 32'hDEADBEEF);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("read data holds", read_data[0], 32'hDEADBEEF);
        @(posedge clk);
        #1;

        $display("[TB] rd_en and wr_en together");
        do_txn(0, 1'b1, 1'b1, 32'd1024, 32'h12345678, low);
        check_output("both busy cycles", 32'(low), 32'd5);
        check_output("both we_n low count", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() >= 1) begin
            check_output("both lo dq", 32'(wr_dq_q[0]), 32'h00005678);
        end
        do_txn(0, 1'b1, 1'b0, 32'd1024, 32'd0, low);
        check_output("both read back", done_read_data, 32'h12345678);

        $display("[TB] reset during a write");
        do_txn(0, 1'b0, 1'b1, 32'd1040, 32'hAAAA5555, low);
        apply_stimulus(0, 1'b0, 1'b1, 32'd1040, 32'h11112222);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply_stimulus(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("abort ready", 32'(ready[0]), 32'd1);
        check_output("abort we_n", 32'(sram_we_n[0]), 32'd1);
        check_output("abort oe_n", 32'(sram_oe_n[0]), 32'd1);
        check_output("abort dq_oe", 32'(sram_dq_oe[0]), 32'd0);
        @(posedge clk);
        #1;
        do_txn(0, 1'b1, 1'b0, 32'd1040, 32'd0, low);
        check_output("abort high half kept", 32'(done_read_data[31:16]), 32'h0000AAAA);

        $display("[TB] back-to-back read then write, 3 wait cycles");
        do_txn(1, 1'b1, 1'b0, 32'd1024 + 32'd4 * (32'd1 << 17), 32'd0, low);
        do_txn(1, 1'b0, 1'b1, 32'd1028, 32'hCAFEF00D, low2);
        check_output("b2b read busy cycles", 32'(low), 32'd7);
        check_output("b2b write busy cycles", 32'(low2), 32'd7);
        check_output("b2b write we_n low count", 32'(wr_addr_q.size()), 32'd4);
        do_txn(1, 1'b1, 1'b0, 32'd1028, 32'd0, low);
        check_output("b2b read back", done_read_data, 32'hCAFEF00D);
        do_txn(1, 1'b1, 1'b0, 32'd1024 + 32'd4 * (32'd1 << 17), 32'd0, low);
        check_output("wrap sram_addr", 32'(rd_first_addr), 32'd0);
        check_output("wrap read data", done_read_data, 32'hA5A4A5A5);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/sram_data_controller.md
Name: sram_data_controller

Overview:
- Memory-side responder for the pipeline's MEM stage: accepts one 32-bit read or write request and serves it from an external 16-bit asynchronous SRAM as two half-word accesses.
- Sits between the EXEC stage register outputs (rd_en, wr_en, address, write_data) and the SRAM pins.
- Drives ready low while busy; the top level ORs ~ready into the global freeze so every pipeline register holds until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM half-word 0.
- SRAM_AW, 18: SRAM address width in half-words.
- WAIT_CYCLES, 2: clock cycles spent on each half-word access; legal values 2..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read request from the EXEC stage register
- wr_en  in  1  write request from the EXEC stage register
- address  in  32  byte address, word-aligned
- write_data  in  32  store data
- read_data  out  32  load result, valid while ready=1 after a read
- ready  out  1  0 = busy, pipeline must freeze
- sram_addr  out  SRAM_AW  half-word address
- sram_dq_o  out  16  write data to the pad
- sram_dq_i  in  16  read data from the pad
- sram_dq_oe  out  1  pad output enable; the tristate buffer lives in the top level
- sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- State on reset: IDLE, cnt=0, read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
- Constant strobes: sram_ce_n, sram_ub_n and sram_lb_n are tied to 0.
- Address mapping: widx = (address - BASE_ADDR) >> 2, truncated to SRAM_AW-1 bits. Out-of-range addresses wrap silently; there is no error.
  - Low half-word at {widx,0}, holding bits [15:0].
  - High half-word at {widx,1}, holding bits [31:16].
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - ready = ~(rd_en | wr_en), combinational, so it drops in the same cycle a request appears.
  - On a request: latch op, widx and write_data, clear cnt, go to LO.
  - If rd_en and wr_en are both high, the write wins.
- LO and HI:
  - ready=0.
  - sram_addr is driven from the latched index.
  - cnt counts from 0 to WAIT_CYCLES-1; the state advances when cnt = WAIT_CYCLES-1 (LO goes to HI, HI goes to DONE) and cnt clears.
  - Read: sram_oe_n=0 and sram_dq_oe=0. sram_dq_i is sampled into read_data[15:0] or [31:16] on the final cycle of the state.
  - Write: sram_dq_oe=1 and sram_dq_o carries the latched half.
    - sram_we_n=0 for cycles 0..WAIT_CYCLES-2 and 1 on the final cycle, so data is held past the rising edge of WE.
    - read_data is unchanged.
- DONE:
  - ready=1 for exactly one cycle; all strobes are inactive.
  - The pipeline advances on this edge; the next state is IDLE unconditionally.
  - A request still visible in the DONE cycle belongs to the retiring instruction and is ignored.
- Latency: request first seen in cycle 0. ready is low for 2*WAIT_CYCLES+1 cycles and high in cycle 2*WAIT_CYCLES+1. With the default this is 5 low cycles, then 1 high.
- read_data holds its last value until the next read completes; a write never alters it.
- Reset mid-operation: the access is abandoned, all outputs return to reset values, and a partial write may leave only the low half updated.
- Back-to-back requests: a new request in the cycle after DONE is accepted normally, so there is no dead cycle beyond DONE.

Decomposition:
- Shared package sram_ctrl_pkg holds:
  - the state enum (IDLE, LO, HI, DONE);
  - the constants HALF_LO=1'b0 and HALF_HI=1'b1;
  - the default BASE_ADDR.
- One sub-module is natural: sram_wait_counter (cnt, clear, terminal-count flag).
- The FSM and datapath stay in sram_data_controller.

Test Plan:
- Reset, then idle with no request -> ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
- Write at address 1024+8, data 0xDEADBEEF, WAIT=2 -> sram_addr 4 with dq 0xBEEF, then 5 with 0xDEAD; each has sram_we_n low for 1 cycle; ready is low 5 cycles, then high 1.
- Read back 1032 with an SRAM model -> read_data=0xDEADBEEF in the DONE cycle, and it holds after return to IDLE.
- rd_en and wr_en both asserted with data 0x12345678 at address 1024 -> a write occurs; a subsequent read returns 0x12345678.
- rst asserted during LO of a write -> the next cycle is IDLE with all strobes inactive; a later read of the high half-word returns its prior contents.
- Back-to-back read then write, WAIT=3 -> two 7-cycle busy windows separated by exactly one ready=1 cycle; address 1024+4*2^17 wraps to sram_addr 0.
